// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block:
// op encodings, default datapath width and the sequencer state type.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant.
// Ports: valid[1:0] requests, prio (favoured id on a tie),
//        grant[1:0] one-hot grant, id (index of the grant).
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       id
);

    assign grant[0] = valid[0] & (~valid[1] | ~prio);
    assign grant[1] = valid[1] & (~valid[0] |  prio);
    assign id       = grant[1];

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external ALU between two requesters.
// Ports: clk/rst (sync, active high); req0_*/req1_* valid/ready
//        requests with a, b, op; alu_a/alu_b/alu_op to the ALU and
//        alu_z/alu_ex back; rsp_* tagged response channel.
// Option ALU_OPCHK_EN: illegal ops bypass the ALU and answer
//        with rsp_err=1 (extra port rsp_err).
module alu_share_arb #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_z,
    input  logic             alu_ex,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
`ifdef ALU_OPCHK_EN
    output logic             rsp_ex,
    output logic             rsp_err
`else
    output logic             rsp_ex
`endif
);

    import alu_pkg::*;

    state_t           state_q, state_d;
    logic             prio_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic             id_q;

    logic [NREQ-1:0]  vld, gnt;
    logic             gid;
    logic             take, skip;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       sel_op;

    assign vld = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .valid (vld),
        .prio  (prio_q),
        .grant (gnt),
        .id    (gid)
    );

    always_comb begin
        sel_a  = gid ? req1_a  : req0_a;
        sel_b  = gid ? req1_b  : req0_b;
        sel_op = gid ? req1_op : req0_op;
    end

    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        take       = 1'b0;
        skip       = 1'b0;
        unique case (state_q)
            IDLE: begin
                req0_ready = gnt[0] & ~rst;
                req1_ready = gnt[1] & ~rst;
                take       = |gnt;
                if (take) state_d = EXEC;
`ifdef ALU_OPCHK_EN
                if (take && !op_legal(sel_op)) begin
                    skip    = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 3'b000;
            id_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_z     <= '0;
            rsp_ex    <= 1'b0;
`ifdef ALU_OPCHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (take) begin
                id_q <= gid;
                // Toggle only on a real contest.
                if (&vld) prio_q <= ~gid;
                // Rejected ops leave the ALU ports untouched.
                if (!skip) begin
                    a_q  <= sel_a;
                    b_q  <= sel_b;
                    op_q <= sel_op;
                end
            end
            if (state_q == EXEC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_q;
                rsp_z     <= alu_z;
                rsp_ex    <= alu_ex;
`ifdef ALU_OPCHK_EN
                rsp_err   <= 1'b0;
`endif
            end
`ifdef ALU_OPCHK_EN
            if (skip) begin
                rsp_valid <= 1'b1;
                rsp_id    <= gid;
                rsp_z     <= '0;
                rsp_ex    <= 1'b0;
                rsp_err   <= 1'b1;
            end
`endif
            if (state_q == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

endmodule
